text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
//
// PURPOSE
//  Character-stream front end for the 80x30 text-mode VRAM scanned by the VGA controller.
//  - Accepts one byte per valid/ready handshake and keeps a cursor.
//  - Writes glyph codes into VRAM and interprets CR, LF, BS and FF.
//  - Wraps at end of line and scrolls the screen up one row when output passes the last row.
//  - Sits between the CPU/UART character source and the write port of the dual-port VRAM.
//
// PARAMETERS
//  COLS        80     visible text columns (1..128)
//  ROWS        30     visible text rows (1..32)
//  BLANK_CHAR  8'h20  glyph code used for clear, scroll fill and backspace erase
//
// PORTS
//  clk_i           in   1   pixel/system clock
//  rst_i           in   1   reset, asynchronous, active-high
//  char_i          in   8   byte to display / control code
//  char_valid_i    in   1   char_i valid
//  char_ready_o    out  1   block can accept char_i this cycle
//  vram_rd_addr_o  out  12  VRAM read address {row[4:0], col[6:0]}
//  vram_rd_data_i  in   8   VRAM read data, valid 1 cycle after the address
//  vram_wr_addr_o  out  12  VRAM write address {row[4:0], col[6:0]}
//  vram_wr_data_o  out  8   VRAM write data
//  vram_we_o       out  1   VRAM write enable
//  cursor_col_o    out  7   current cursor column
//  cursor_row_o    out  5   current cursor row
//
// BEHAVIOUR
//  - Clock and reset: one clock, clk_i. Reset is asynchronous and active-high.
//    - While rst_i is high: every output is 0; internal state is CLEAR at (0,0).
//    - Reset mid-operation aborts any clear or scroll; vram_we_o drops immediately.
//  - VRAM addressing: address = {row, col}, so the row stride is 128.
//    - Columns COLS..127 and rows ROWS..31 are never written.
//  - All outputs are registered. A write appears on the VRAM port in the cycle after the edge that decided it.
//  - Handshake:
//    - A byte is accepted on a rising edge with char_valid_i && char_ready_o.
//    - char_ready_o = 1 only in IDLE, so the block sustains 1 byte/cycle when no scroll or clear is needed.
//  - States:
//    - IDLE
//      - accept bytes;
//      - if no byte is accepted: vram_we_o = 0, vram_rd_addr_o / vram_wr_addr_o / vram_wr_data_o hold, cursor holds.
//    - CLEAR: writes BLANK_CHAR to every visible cell, row-major, one per cycle (ROWS*COLS cycles).
//      - Then cursor = (0,0) and next state IDLE.
//    - SCROLL: pipelined copy, one cell per cycle.
//      - Read (r,c) for r = 1..ROWS-1 and write it to (r-1,c) one cycle later.
//      - Then write BLANK_CHAR to row ROWS-1 (COLS cycles).
//      - Then IDLE with cursor (0,ROWS-1).
//      - Total busy time is ROWS*COLS cycles ±1 for pipeline fill.
//  - Byte decode in IDLE (cursor (c,r)):
//    - 0x0D CR: c = 0, no write.
//    - 0x0A LF: c = 0; if r < ROWS-1 then r+1, else enter SCROLL. No write.
//    - 0x08 BS: if c > 0, then c-1 and write BLANK_CHAR at (c-1,r); if c == 0, no-op.
//    - 0x0C FF: enter CLEAR.
//    - Any other code:
//      - write it at (c,r);
//      - if c < COLS-1, c+1;
//      - otherwise c = 0 and treat it as an LF (scrolls when r == ROWS-1).
//  - Cursor invariant: the cursor is always within the visible area. A cursor outside the visible area is unreachable.
//  - Simultaneous events: none beyond reset. No bytes are accepted while in CLEAR or SCROLL.
//
// STRUCTURE
//  - common package gets:
//    - vram_addr_t (12-bit);
//    - TEXT_COLS / TEXT_ROWS defaults;
//    - CHAR_BS / CHAR_LF / CHAR_FF / CHAR_CR / CHAR_SPACE constants.
//  - One flat module. The only sub-block is the state enum {IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL}.
//  - No sub-module; the sweep counter (row,col) is shared by CLEAR and SCROLL.
//
// TESTING  (bench models VRAM as a 4096x8 dual-port RAM with 1-cycle read latency)
//  1. Reset release:
//     - exactly 2400 writes of 0x20, covering addresses {r,c} for r<30, c<80;
//     - then char_ready_o = 1 and cursor = (0,0).
//  2. Send 0x41 then 0x42 on back-to-back cycles at (0,0):
//     - writes (0x000,0x41) then (0x001,0x42) on consecutive cycles;
//     - cursor ends at (2,0).
//  3. Cursor at (79,5), send 0x41:
//     - single write (0x2CF,0x41);
//     - cursor becomes (0,6); no scroll.
//  4. Cursor at (79,29), send 0x5A:
//     - write (0xECF,0x5A);
//     - char_ready_o stays low for about 2400 cycles;
//     - afterwards row r holds the former row r+1, row 29 is all 0x20, and cursor = (0,29).
//  5. Control codes:
//     - BS at (3,2) → write (0x102,0x20) and cursor becomes (2,2);
//     - BS at (0,2) → no write;
//     - CR at (5,7) → cursor (0,7);
//     - LF at (5,7) → cursor (0,8);
//     - FF → full clear, then cursor (0,0).
//  6. Assert rst_i 100 cycles into a scroll:
//     - vram_we_o = 0 in the same cycle;
//     - after release, a full 2400-cell clear runs again from address 0x000.

Source files
------------

// File: rtl/text_console_writer_pkg.sv
// ============================================================================
// Module      : text_console_writer_pkg
// Description : Shared types and character codes for the text console writer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package text_console_writer_pkg;

    typedef logic [11:0] vram_addr_t;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CLEAR       = 2'd1,
        ST_SCROLL_COPY = 2'd2,
        ST_SCROLL_FILL = 2'd3
    } state_t;

    function automatic vram_addr_t make_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/text_console_writer.sv
// ============================================================================
// Module      : text_console_writer
// Description : Byte-stream front end writing glyphs, cursor control, clear
//               and scroll into an 80x30 text VRAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int         COLS       = TEXT_COLS,
    parameter int         ROWS       = TEXT_ROWS,
    parameter logic [7:0] BLANK_CHAR = CHAR_SPACE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [11:0] vram_rd_addr_o,
    input  logic [7:0]  vram_rd_data_i,
    output logic [11:0] vram_wr_addr_o,
    output logic [7:0]  vram_wr_data_o,
    output logic        vram_we_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o
);

    localparam logic [6:0] c_LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0] c_LAST_ROW  = 5'(ROWS - 1);
    localparam bit         c_FILL_ONLY = (ROWS == 1);

    state_t     r_state;
    logic [4:0] r_sweep_row;
    logic [6:0] r_sweep_col;
    logic       r_fill_done;

    // Two-stage copy pipeline: address leaves on vram_rd_addr_o, RAM returns
    // data one cycle later, so the write target travels two stages behind.
    logic       r_p1_valid, r_p2_valid;
    logic       r_p1_blank, r_p2_blank;
    vram_addr_t r_p1_addr,  r_p2_addr;

    logic       w_sweep_last;
    logic [6:0] w_next_col;
    logic [4:0] w_next_row;
    logic       w_wr;
    vram_addr_t w_wr_addr;
    logic [7:0] w_wr_data;
    logic       w_go_scroll;
    logic       w_go_clear;
    logic       w_accept;

    assign w_sweep_last = (r_sweep_row == c_LAST_ROW) && (r_sweep_col == c_LAST_COL);
    assign w_accept     = char_valid_i && char_ready_o;

    always_comb begin
        w_next_col  = cursor_col_o;
        w_next_row  = cursor_row_o;
        w_wr        = 1'b0;
        w_wr_addr   = make_addr(cursor_row_o, cursor_col_o);
        w_wr_data   = char_i;
        w_go_scroll = 1'b0;
        w_go_clear  = 1'b0;
        case (char_i)
            CHAR_CR: w_next_col = '0;
            CHAR_LF: begin
                w_next_col = '0;
                if (cursor_row_o == c_LAST_ROW) w_go_scroll = 1'b1;
                else                            w_next_row  = cursor_row_o + 5'd1;
            end
            CHAR_BS: begin
                if (cursor_col_o != '0) begin
                    w_next_col = cursor_col_o - 7'd1;
                    w_wr       = 1'b1;
                    w_wr_addr  = make_addr(cursor_row_o, cursor_col_o - 7'd1);
                    w_wr_data  = BLANK_CHAR;
                end
            end
            CHAR_FF: w_go_clear = 1'b1;
            default: begin
                w_wr = 1'b1;
                if (cursor_col_o != c_LAST_COL) begin
                    w_next_col = cursor_col_o + 7'd1;
                end else begin
                    w_next_col = '0;
                    if (cursor_row_o == c_LAST_ROW) w_go_scroll = 1'b1;
                    else                            w_next_row  = cursor_row_o + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_CLEAR;
            r_sweep_row    <= '0;
            r_sweep_col    <= '0;
            r_fill_done    <= 1'b0;
            r_p1_valid     <= 1'b0;
            r_p2_valid     <= 1'b0;
            r_p1_blank     <= 1'b0;
            r_p2_blank     <= 1'b0;
            r_p1_addr      <= '0;
            r_p2_addr      <= '0;
            char_ready_o   <= 1'b0;
            vram_rd_addr_o <= '0;
            vram_wr_addr_o <= '0;
            vram_wr_data_o <= '0;
            vram_we_o      <= 1'b0;
            cursor_col_o   <= '0;
            cursor_row_o   <= '0;
        end else begin
            vram_we_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        cursor_col_o <= w_next_col;
                        cursor_row_o <= w_next_row;
                        if (w_wr) begin
                            vram_we_o      <= 1'b1;
                            vram_wr_addr_o <= w_wr_addr;
                            vram_wr_data_o <= w_wr_data;
                        end
                        if (w_go_clear) begin
                            r_state      <= ST_CLEAR;
                            r_sweep_row  <= '0;
                            r_sweep_col  <= '0;
                            char_ready_o <= 1'b0;
                        end else if (w_go_scroll) begin
                            r_state      <= c_FILL_ONLY ? ST_SCROLL_FILL : ST_SCROLL_COPY;
                            r_sweep_row  <= c_FILL_ONLY ? c_LAST_ROW : 5'd1;
                            r_sweep_col  <= '0;
                            r_fill_done  <= 1'b0;
                            char_ready_o <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    vram_we_o      <= 1'b1;
                    vram_wr_addr_o <= make_addr(r_sweep_row, r_sweep_col);
                    vram_wr_data_o <= BLANK_CHAR;
                    if (w_sweep_last) begin
                        r_state      <= ST_IDLE;
                        char_ready_o <= 1'b1;
                        cursor_col_o <= '0;
                        cursor_row_o <= '0;
                    end else if (r_sweep_col == c_LAST_COL) begin
                        r_sweep_col <= '0;
                        r_sweep_row <= r_sweep_row + 5'd1;
                    end else begin
                        r_sweep_col <= r_sweep_col + 7'd1;
                    end
                end

                default: begin
                    r_p2_valid <= r_p1_valid;
                    r_p2_blank <= r_p1_blank;
                    r_p2_addr  <= r_p1_addr;
                    if (r_p2_valid) begin
                        vram_we_o      <= 1'b1;
                        vram_wr_addr_o <= r_p2_addr;
                        vram_wr_data_o <= r_p2_blank ? BLANK_CHAR : vram_rd_data_i;
                    end
                    if (r_state == ST_SCROLL_COPY) begin
                        vram_rd_addr_o <= make_addr(r_sweep_row, r_sweep_col);
                        r_p1_valid     <= 1'b1;
                        r_p1_blank     <= 1'b0;
                        r_p1_addr      <= make_addr(r_sweep_row - 5'd1, r_sweep_col);
                        if (w_sweep_last) begin
                            r_state     <= ST_SCROLL_FILL;
                            r_sweep_row <= c_LAST_ROW;
                            r_sweep_col <= '0;
                        end else if (r_sweep_col == c_LAST_COL) begin
                            r_sweep_col <= '0;
                            r_sweep_row <= r_sweep_row + 5'd1;
                        end else begin
                            r_sweep_col <= r_sweep_col + 7'd1;
                        end
                    end else if (!r_fill_done) begin
                        r_p1_valid <= 1'b1;
                        r_p1_blank <= 1'b1;
                        r_p1_addr  <= make_addr(c_LAST_ROW, r_sweep_col);
                        if (r_sweep_col == c_LAST_COL) r_fill_done <= 1'b1;
                        else                           r_sweep_col <= r_sweep_col + 7'd1;
                    end else begin
                        r_p1_valid <= 1'b0;
                        // Last queued blank is being written on this edge.
                        if (!r_p1_valid && r_p2_valid) begin
                            r_state      <= ST_IDLE;
                            char_ready_o <= 1'b1;
                            cursor_col_o <= '0;
                            cursor_row_o <= c_LAST_ROW;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// ============================================================================
// Module      : tb_text_console_writer
// Description : Scoreboard bench for text_console_writer with a 1-cycle VRAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_text_console_writer;
    import text_console_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        we;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    always #5 clk = ~clk;

    text_console_writer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .char_i         (char_in),
        .char_valid_i   (char_valid),
        .char_ready_o   (char_ready),
        .vram_rd_addr_o (rd_addr),
        .vram_rd_data_i (rd_data),
        .vram_wr_addr_o (wr_addr),
        .vram_wr_data_o (wr_data),
        .vram_we_o      (we),
        .cursor_col_o   (cur_col),
        .cursor_row_o   (cur_row)
    );

    logic [7:0] mem    [4096];
    logic [7:0] shadow [4096];

    always @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    typedef struct packed {logic [11:0] a; logic [7:0] d;} wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc_prev = 0;
    int wr_cyc_last = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every VRAM write must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%03h/%02h expected=none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("vram_write", int'({wr_addr, wr_data}), int'(e));
            end
            wr_cyc_prev = wr_cyc_last;
            wr_cyc_last = cyc;
        end
    end

    task automatic push_exp(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        shadow[a] = d;
    endtask

    task automatic push_clear();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                push_exp({5'(r), 7'(c)}, 8'h20);
    endtask

    task automatic push_scroll();
        for (int r = 0; r < 29; r++)
            for (int c = 0; c < 80; c++)
                push_exp({5'(r), 7'(c)}, shadow[{5'(r + 1), 7'(c)}]);
        for (int c = 0; c < 80; c++)
            push_exp({5'd29, 7'(c)}, 8'h20);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((!char_ready || exp_q.size() != 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d expected=0 pending", exp_q.size());
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, int'(cur_col), col);
        check({name, "_row"}, int'(cur_row), row);
    endtask

    task automatic compare_screen(input string name);
        int bad = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                if (mem[{5'(r), 7'(c)}] !== shadow[{5'(r), 7'(c)}]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_ready", int'(char_ready), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check_cursor("rst_cursor", 0, 0);

        // 1: power-on clear
        push_clear();
        rst = 1'b0;
        wait_idle();
        check("clear_ready", int'(char_ready), 1);
        check_cursor("clear_cursor", 0, 0);

        // 2: back-to-back glyphs
        push_exp(12'h000, 8'h41);
        push_exp(12'h001, 8'h42);
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle();
        check("b2b_gap", wr_cyc_last - wr_cyc_prev, 1);
        check_cursor("b2b_cursor", 2, 0);

        // 3: wrap at end of line without scroll
        send_byte(CHAR_CR);
        for (int i = 0; i < 5; i++) send_byte(CHAR_LF);
        for (int i = 0; i < 79; i++) begin
            push_exp({5'd5, 7'(i)}, 8'h30 + 8'(i % 10));
            send_byte(8'h30 + 8'(i % 10));
        end
        wait_idle();
        check_cursor("eol_cursor", 79, 5);
        push_exp(12'h2CF, 8'h41);
        send_byte(8'h41);
        wait_idle();
        check_cursor("wrap_cursor", 0, 6);

        // 5: control codes
        push_clear();
        send_byte(CHAR_FF);
        wait_idle();
        check_cursor("ff_cursor", 0, 0);
        send_byte(CHAR_LF);
        send_byte(CHAR_LF);
        push_exp(12'h100, 8'h61);
        push_exp(12'h101, 8'h62);
        push_exp(12'h102, 8'h63);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        wait_idle();
        check_cursor("pre_bs_cursor", 3, 2);
        push_exp(12'h102, 8'h20);
        send_byte(CHAR_BS);
        wait_idle();
        check_cursor("bs_cursor", 2, 2);
        push_exp(12'h101, 8'h20);
        push_exp(12'h100, 8'h20);
        send_byte(CHAR_BS);
        send_byte(CHAR_BS);
        send_byte(CHAR_BS);
        wait_idle();
        repeat (5) @(negedge clk);
        check_cursor("bs_col0_cursor", 0, 2);
        for (int i = 0; i < 5; i++) send_byte(CHAR_LF);
        for (int i = 0; i < 5; i++) begin
            push_exp({5'd7, 7'(i)}, 8'h70 + 8'(i));
            send_byte(8'h70 + 8'(i));
        end
        wait_idle();
        check_cursor("pre_cr_cursor", 5, 7);
        send_byte(CHAR_CR);
        wait_idle();
        check_cursor("cr_cursor", 0, 7);
        for (int i = 0; i < 5; i++) begin
            push_exp({5'd7, 7'(i)}, 8'h50 + 8'(i));
            send_byte(8'h50 + 8'(i));
        end
        send_byte(CHAR_LF);
        wait_idle();
        check_cursor("lf_cursor", 0, 8);

        // 4: wrap on last row scrolls
        for (int i = 0; i < 21; i++) send_byte(CHAR_LF);
        for (int i = 0; i < 79; i++) begin
            push_exp({5'd29, 7'(i)}, 8'h41 + 8'(i % 26));
            send_byte(8'h41 + 8'(i % 26));
        end
        wait_idle();
        check_cursor("pre_scroll_cursor", 79, 29);
        push_exp(12'hECF, 8'h5A);
        push_scroll();
        send_byte(8'h5A);
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 2390 || n > 2410) begin
            errors++;
            $display("FAIL scroll_busy actual=%0d expected=2390..2410", n);
        end
        wait_idle();
        check_cursor("scroll_cursor", 0, 29);
        compare_screen("scroll_screen");

        // Form feed full clear
        push_clear();
        send_byte(CHAR_FF);
        wait_idle();
        check_cursor("ff2_cursor", 0, 0);
        compare_screen("ff2_screen");

        // 6: reset in the middle of a scroll
        for (int i = 0; i < 29; i++) send_byte(CHAR_LF);
        wait_idle();
        push_scroll();
        send_byte(CHAR_LF);
        repeat (100) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_we", int'(we), 0);
        check("mid_rst_ready", int'(char_ready), 0);
        check_cursor("mid_rst_cursor", 0, 0);
        exp_q.delete();
        push_clear();
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        check_cursor("post_rst_cursor", 0, 0);
        compare_screen("post_rst_screen");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
